// File: rtl/button_event.sv
// button_event: turns the debounced button level into single-cycle event
// pulses (press, release, short click, long press, auto-repeat) plus a
// "held" level. Defining BTN_DOUBLE_CLICK_EN adds double-click detection.
// In that build the short click is deferred until the double-click window
// has expired.
// The output names carry an _o suffix because "release" and "repeat" are
// SystemVerilog keywords and cannot be used as port names.
module button_event #(
  parameter int unsigned LONG_TICKS   = 100_000_000,
  parameter int unsigned REPEAT_TICKS = 20_000_000,
  parameter int unsigned DCLICK_TICKS = 30_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic db_in,
  output logic press_o,
  output logic release_o,
  output logic short_click_o,
  output logic long_press_o,
  output logic repeat_o,
`ifdef BTN_DOUBLE_CLICK_EN
  output logic double_click_o,
`endif
  output logic held_o
);

  // Ceiling for the counter in states without a threshold. Holding the count
  // here keeps it from wrapping while the button idles.
  localparam int unsigned MaxA     = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned MaxTicks = (MaxA > DCLICK_TICKS) ? MaxA : DCLICK_TICKS;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] MaxLast    = CNT_W'(MaxTicks - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_TICKS - 1);

  typedef enum logic [2:0] {IDLE, PRESSED, HELD, WAIT_DC, PRESSED2} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             rise, fall;
`ifdef BTN_DOUBLE_CLICK_EN
  logic             dclick_q, dclick_d;
`endif

  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;

  // State, counter, edge-detect history and registered outputs.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
      dclick_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_q      <= db_in;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
`ifdef BTN_DOUBLE_CLICK_EN
      dclick_q  <= dclick_d;
`endif
    end
  end

  // Next-state and pulse decisions; edges take priority over timeouts so a
  // release on the threshold cycle is never reported as a long press.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == MaxLast) ? cnt_q : cnt_q + CNT_W'(1);
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
    dclick_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
`ifdef BTN_DOUBLE_CLICK_EN
          state_d   = WAIT_DC;
`else
          short_d   = 1'b1;
          state_d   = IDLE;
`endif
        end else if (cnt_q == LongLast) begin
          long_d  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else if (cnt_q == RepeatLast) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      WAIT_DC: begin
        if (rise) begin
          press_d  = 1'b1;
          dclick_d = 1'b1;
          state_d  = PRESSED2;
          cnt_d    = '0;
        end else if (cnt_q == DclickLast) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      PRESSED2: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD);
  end

  assign press_o        = press_q;
  assign release_o      = release_q;
  assign short_click_o  = short_q;
  assign long_press_o   = long_q;
  assign repeat_o       = repeat_q;
  assign held_o         = held_q;
`ifdef BTN_DOUBLE_CLICK_EN
  assign double_click_o = dclick_q;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed testbench for button_event with LONG_TICKS=100, REPEAT_TICKS=20,
// DCLICK_TICKS=50. Covers both builds of BTN_DOUBLE_CLICK_EN.
module tb_button_event;

  logic clock;
  logic reset;
  logic dbIn;
  logic pressO, releaseO, shortO, longO, repeatO, heldO, dclickO;
  logic [6:0] obsVec;
  int checks;
  int errors;

  // Output bit positions in obsVec
  localparam logic [6:0] P = 7'b1000000;
  localparam logic [6:0] R = 7'b0100000;
  localparam logic [6:0] S = 7'b0010000;
  localparam logic [6:0] L = 7'b0001000;
  localparam logic [6:0] T = 7'b0000100;
  localparam logic [6:0] H = 7'b0000010;
  localparam logic [6:0] D = 7'b0000001;
  localparam logic [6:0] Z = 7'b0000000;

  button_event #(
    .LONG_TICKS(100),
    .REPEAT_TICKS(20),
    .DCLICK_TICKS(50),
    .CNT_W(8)
  ) dut (
    .CLK100MHZ(clock),
    .reset(reset),
    .db_in(dbIn),
    .press_o(pressO),
    .release_o(releaseO),
    .short_click_o(shortO),
    .long_press_o(longO),
    .repeat_o(repeatO),
`ifdef BTN_DOUBLE_CLICK_EN
    .double_click_o(dclickO),
`endif
    .held_o(heldO)
  );

`ifndef BTN_DOUBLE_CLICK_EN
  assign dclickO = 1'b0;
`endif

  assign obsVec = {pressO, releaseO, shortO, longO, repeatO, heldO, dclickO};

  // 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expVec);
    checks++;
    assert (obsVec === expVec)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (press,release,short,long,repeat,held,dclick)",
             tag, obsVec, expVec);
    end
  endtask

  // Hold dbIn at level for n cycles; first cycle expects firstExp, the rest restExp
  task automatic applyStimulus(input logic level, input int n, input string tag,
                               input logic [6:0] firstExp, input logic [6:0] restExp);
    dbIn = level;
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput($sformatf("%s[%0d]", tag, i), (i == 0) ? firstExp : restExp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    dbIn   = 1'b0;

    // Reset state
    #3;
    checkOutput("resetState", Z);
    tick();
    checkOutput("resetHold", Z);
    #2 reset = 1'b0;
    applyStimulus(1'b0, 3, "idle", Z, Z);

    // Short click: 30 cycles high then release
    applyStimulus(1'b1, 30, "click", P, Z);
`ifdef BTN_DOUBLE_CLICK_EN
    applyStimulus(1'b0, 50, "clickRel", R, Z);
    applyStimulus(1'b0, 1, "clickTimeout", S, Z);
    applyStimulus(1'b0, 5, "clickQuiet", Z, Z);
`else
    applyStimulus(1'b0, 5, "clickRel", R | S, Z);
`endif

    // Long hold: 170 cycles high
    applyStimulus(1'b1, 100, "holdPre", P, Z);
    applyStimulus(1'b1, 20, "holdLong", L | H, H);
    applyStimulus(1'b1, 20, "holdRep1", T | H, H);
    applyStimulus(1'b1, 20, "holdRep2", T | H, H);
    applyStimulus(1'b1, 10, "holdRep3", T | H, H);
    applyStimulus(1'b0, 60, "holdRel", R, Z);

    // Fall sampled on the same edge the counter reaches 99
    applyStimulus(1'b1, 100, "coinc", P, Z);
`ifdef BTN_DOUBLE_CLICK_EN
    applyStimulus(1'b0, 50, "coincRel", R, Z);
    applyStimulus(1'b0, 1, "coincTimeout", S, Z);
    applyStimulus(1'b0, 3, "coincQuiet", Z, Z);
`else
    applyStimulus(1'b0, 5, "coincRel", R | S, Z);
`endif

`ifdef BTN_DOUBLE_CLICK_EN
    // Double click: press 20, gap 30, press again held past the long threshold
    applyStimulus(1'b1, 20, "dc1", P, Z);
    applyStimulus(1'b0, 30, "dcGap", R, Z);
    applyStimulus(1'b1, 110, "dc2", P | D, Z);
    applyStimulus(1'b0, 60, "dcRel", R, Z);
`endif

    // Reset asserted 60 cycles into a press, released with dbIn still high
    applyStimulus(1'b1, 60, "rstPre", P, Z);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstAsync", Z);
    tick();
    checkOutput("rstHold0", Z);
    tick();
    checkOutput("rstHold1", Z);
    #2 reset = 1'b0;
    applyStimulus(1'b1, 100, "rstPress", P, Z);
    applyStimulus(1'b1, 1, "rstLong", L | H, H);
    applyStimulus(1'b0, 3, "rstRel", R, Z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
